// File: rtl/rf_op_sequencer_if.sv
// Command/response handshake bundle between micro-control and the RF op sequencer.
interface rf_op_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_dst;
  logic [2:0]        cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              op_done;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, op_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, op_done, cmd_err
  );
endinterface

// File: rtl/rf_op_sequencer.sv
// Sequences one register-file command at a time into the RF select/function/data lines.
// SWAP moves through a scratch T register over three cycles; READ returns data on a rsp handshake.
module rf_op_sequencer #(
  parameter int         DATA_W  = 8,
  parameter logic [2:0] SCRATCH = 3'd3
) (
  input  logic              clk,
  input  logic              reset,
  rf_op_sequencer_if.slave  bus,
  output logic [2:0]        rf_o1sel,
  output logic [2:0]        rf_o2sel,
  output logic [1:0]        rf_funsel,
  output logic [3:0]        rf_rsel,
  output logic [3:0]        rf_tsel,
  output logic [DATA_W-1:0] rf_i,
  input  logic [DATA_W-1:0] rf_o1,
  input  logic [DATA_W-1:0] rf_o2
);
  typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, RESP} state_t;

  localparam logic [2:0] OP_CLR = 3'b000, OP_INC = 3'b001, OP_DEC = 3'b010, OP_LDI = 3'b011,
                         OP_MOV = 3'b100, OP_SWAP = 3'b101, OP_READ = 3'b110, OP_CLRALL = 3'b111;
  localparam logic [1:0] F_DEC = 2'b00, F_INC = 2'b01, F_LOAD = 2'b10, F_CLR = 2'b11;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d, dst_q, dst_d, src_q, src_d;
  logic [DATA_W-1:0] imm_q, imm_d, rsp_data_q, rsp_data_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        en;
  logic              swap_bad;

  // {rsel, tsel} one-hot enable for a register index; bit3 of each nibble is index 0 of its bank
  function automatic logic [7:0] dec(input logic [2:0] idx);
    logic [3:0] oh;
    oh = 4'b1000 >> idx[1:0];
    return idx[2] ? {oh, 4'b0000} : {4'b0000, oh};
  endfunction

  assign swap_bad = (src_q == SCRATCH) || (dst_q == SCRATCH);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    src_d      = src_q;
    imm_d      = imm_q;
    rsp_data_d = rsp_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    en         = 8'h00;
    rf_o1sel   = 3'd0;
    rf_o2sel   = 3'd0;
    rf_funsel  = F_DEC;
    rf_i       = '0;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d    = bus.cmd_op;
        dst_d   = bus.cmd_dst;
        src_d   = bus.cmd_src;
        imm_d   = bus.cmd_imm;
        state_d = EX1;
      end
      EX1: begin
        state_d = IDLE;
        done_d  = 1'b1;
        unique case (op_q)
          OP_CLR:    begin en = dec(dst_q); rf_funsel = F_CLR; end
          OP_INC:    begin en = dec(dst_q); rf_funsel = F_INC; end
          OP_DEC:    begin en = dec(dst_q); rf_funsel = F_DEC; end
          OP_LDI:    begin en = dec(dst_q); rf_funsel = F_LOAD; rf_i = imm_q; end
          OP_MOV:    begin en = dec(dst_q); rf_funsel = F_LOAD; rf_o1sel = src_q; rf_i = rf_o1; end
          OP_CLRALL: begin en = 8'hFF; rf_funsel = F_CLR; end
          OP_READ: begin
            rf_o2sel   = src_q;
            rsp_data_d = rf_o2;
            state_d    = RESP;
            done_d     = 1'b0;
          end
          default: begin
            // SWAP: a scratch collision is rejected before any RF write; dst==src is a no-op
            if (swap_bad) begin
              err_d = 1'b1;
            end else if (dst_q != src_q) begin
              en        = dec(SCRATCH);
              rf_funsel = F_LOAD;
              rf_o1sel  = src_q;
              rf_i      = rf_o1;
              state_d   = EX2;
              done_d    = 1'b0;
            end
          end
        endcase
      end
      EX2: begin
        en        = dec(src_q);
        rf_funsel = F_LOAD;
        rf_o1sel  = dst_q;
        rf_i      = rf_o1;
        state_d   = EX3;
      end
      EX3: begin
        en        = dec(dst_q);
        rf_funsel = F_LOAD;
        rf_o1sel  = SCRATCH;
        rf_i      = rf_o1;
        state_d   = IDLE;
        done_d    = 1'b1;
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {rf_rsel, rf_tsel} = en;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.op_done   = done_q;
  assign bus.cmd_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      dst_q      <= 3'd0;
      src_q      <= 3'd0;
      imm_q      <= '0;
      rsp_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      imm_q      <= imm_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench: sequencer driving a behavioural 8-register file.
module tb_rf_op_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rf_o1sel, rf_o2sel;
  logic [1:0] rf_funsel;
  logic [3:0] rf_rsel, rf_tsel;
  logic [7:0] rf_i, rf_o1, rf_o2;
  logic [7:0] rf [8];
  int         n_pass = 0;
  int         n_total = 0;

  rf_op_sequencer_if #(.DATA_W(8)) bus ();

  rf_op_sequencer #(.DATA_W(8), .SCRATCH(3'd3)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_funsel(rf_funsel),
    .rf_rsel(rf_rsel), .rf_tsel(rf_tsel), .rf_i(rf_i),
    .rf_o1(rf_o1), .rf_o2(rf_o2)
  );

  always #5 clk = ~clk;

  // register file: index 0-3 T1-T4 (tsel bit3..0), 4-7 R1-R4 (rsel bit3..0)
  assign rf_o1 = rf[rf_o1sel];
  assign rf_o2 = rf[rf_o2sel];
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if ((k >= 4) ? rf_rsel[3-(k-4)] : rf_tsel[3-k]) begin
        case (rf_funsel)
          2'b00: rf[k] <= rf[k] - 8'd1;
          2'b01: rf[k] <= rf[k] + 8'd1;
          2'b10: rf[k] <= rf_i;
          default: rf[k] <= 8'd0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // present one command at the next idle cycle; returns after the accept edge (+1)
  task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                      input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src = src; bus.cmd_imm = imm;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_dst = 3'd0; bus.cmd_src = 3'd0;
    bus.cmd_imm = 8'd0; bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsel", rf_rsel, 0);
    check("rst_tsel", rf_tsel, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_op_done", bus.op_done, 0);
    check("rst_rf_i", rf_i, 0);

    // LDI R2 <- 5A
    send(3'b011, 3'b101, 3'b000, 8'h5A);
    @(negedge clk);
    check("ldi_rsel", rf_rsel, 4'b0100);
    check("ldi_tsel", rf_tsel, 4'b0000);
    check("ldi_funsel", rf_funsel, 2'b10);
    check("ldi_rf_i", rf_i, 8'h5A);
    check("ldi_busy", bus.cmd_ready, 0);
    check("ldi_no_done_ex1", bus.op_done, 0);
    @(negedge clk);
    check("ldi_done", bus.op_done, 1);
    check("ldi_err", bus.cmd_err, 0);
    check("ldi_ready_again", bus.cmd_ready, 1);
    check("ldi_r2", rf[5], 8'h5A);

    // MOV T1 <- R3 (R3 preloaded 3C)
    send(3'b011, 3'b110, 3'b000, 8'h3C);
    send(3'b100, 3'b000, 3'b110, 8'h00);
    @(negedge clk);
    check("mov_o1sel", rf_o1sel, 3'b110);
    check("mov_tsel", rf_tsel, 4'b1000);
    check("mov_rsel", rf_rsel, 4'b0000);
    check("mov_rf_i", rf_i, 8'h3C);
    @(negedge clk);
    check("mov_t1", rf[0], 8'h3C);
    check("mov_done", bus.op_done, 1);

    // INC / DEC / CLR on T1
    send(3'b001, 3'b000, 3'b000, 8'h00);
    @(negedge clk);
    check("inc_funsel", rf_funsel, 2'b01);
    @(negedge clk);
    check("inc_t1", rf[0], 8'h3D);
    send(3'b010, 3'b000, 3'b000, 8'h00);
    send(3'b010, 3'b000, 3'b000, 8'h00);
    @(negedge clk); @(negedge clk);
    check("dec_t1", rf[0], 8'h3B);

    // SWAP R4 <-> R1 through T4
    send(3'b011, 3'b100, 3'b000, 8'h11);
    send(3'b011, 3'b111, 3'b000, 8'h22);
    send(3'b101, 3'b111, 3'b100, 8'h00);
    @(negedge clk);
    check("swap1_tsel", rf_tsel, 4'b0001);
    check("swap1_rsel", rf_rsel, 4'b0000);
    check("swap1_o1sel", rf_o1sel, 3'b100);
    @(negedge clk);
    check("swap2_rsel", rf_rsel, 4'b1000);
    check("swap2_tsel", rf_tsel, 4'b0000);
    @(negedge clk);
    check("swap3_rsel", rf_rsel, 4'b0001);
    check("swap3_o1sel", rf_o1sel, 3'b011);
    check("swap3_busy", bus.cmd_ready, 0);
    @(negedge clk);
    check("swap_done", bus.op_done, 1);
    check("swap_r1", rf[4], 8'h22);
    check("swap_r4", rf[7], 8'h11);
    check("swap_t4", rf[3], 8'h11);

    // READ T2 with consumer stalling 3 cycles
    send(3'b011, 3'b001, 3'b000, 8'h7E);
    send(3'b110, 3'b000, 3'b001, 8'h00);
    @(negedge clk);
    check("read_ex1_o2sel", rf_o2sel, 3'b001);
    check("read_ex1_rsp_valid", bus.rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("read_rsp_valid", bus.rsp_valid, 1);
      check("read_rsp_data", bus.rsp_data, 8'h7E);
      check("read_busy", bus.cmd_ready, 0);
      check("read_no_done", bus.op_done, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("read_done", bus.op_done, 1);
    check("read_rsp_dropped", bus.rsp_valid, 0);

    // SWAP touching the scratch register is rejected
    send(3'b101, 3'b100, 3'b011, 8'h00);
    @(negedge clk);
    check("bad_rsel", rf_rsel, 0);
    check("bad_tsel", rf_tsel, 0);
    check("bad_no_done_ex1", bus.op_done, 0);
    @(negedge clk);
    check("bad_done", bus.op_done, 1);
    check("bad_err", bus.cmd_err, 1);
    check("bad_r1_kept", rf[4], 8'h22);
    @(negedge clk);
    check("bad_err_pulse", bus.cmd_err, 0);

    // CLRALL
    send(3'b111, 3'b000, 3'b000, 8'h00);
    @(negedge clk);
    check("clrall_en", {rf_rsel, rf_tsel}, 8'hFF);
    check("clrall_funsel", rf_funsel, 2'b11);
    @(negedge clk);
    check("clrall_r1", rf[4], 8'h00);

    // reset during SWAP EX2
    send(3'b011, 3'b101, 3'b000, 8'hA5);
    send(3'b101, 3'b101, 3'b110, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rswap_ex2_rsel", rf_rsel, 4'b0010);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rswap_ready", bus.cmd_ready, 1);
    check("rswap_rsel", rf_rsel, 0);
    check("rswap_tsel", rf_tsel, 0);
    check("rswap_done", bus.op_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
